register_file_param: RTL

- Parametrised next-generation register file for the 5-stage pipeline datapath.
- Two combinational read ports, two synchronous write ports, and an asynchronous clear.
- Optional write-to-read bypass, so the ID stage sees a WB-stage result in the same cycle.
- Optional hardwired zero register.
- Drop-in superset of the current single-write register file: with WE4 tied low and defaults, the interface behaves as before, except for reset and bypass.

---
 rtl/register_file_param_pkg.sv | 8 +
 rtl/register_file_param_if.sv | 20 ++
 rtl/register_file_param_read_port.sv | 43 ++++
 rtl/register_file_param.sv | 69 ++++++
 4 files changed

// File: rtl/register_file_param_pkg.sv
// Shared constants for the pipeline register file: default geometry and the
// architectural zero-register address.
package rf_pkg;
  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_NUM_REGS  = 32;
  localparam int RF_ZERO_ADDR = 0;
endpackage

// File: rtl/register_file_param_if.sv
// Register-file access bus: two read ports and two write ports.
// master drives addresses, enables and write data; slave returns the read data.
interface register_file_param_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic              WE3;
  logic [DATA_W-1:0] WD3;
  logic [ADDR_W-1:0] A4;
  logic              WE4;
  logic [DATA_W-1:0] WD4;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;

  modport master (output A1, A2, A3, WE3, WD3, A4, WE4, WD4, input RD1, RD2);
  modport slave  (input A1, A2, A3, WE3, WD3, A4, WE4, WD4, output RD1, RD2);
endinterface

// File: rtl/register_file_param_read_port.sv
// One combinational read port: range check, zero-register rule and the
// write-to-read bypass mux (port 4 outranks port 3, matching write priority).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              we3_i,
  input  logic [ADDR_W-1:0] a3_i,
  input  logic [DATA_W-1:0] wd3_i,
  input  logic              we4_i,
  input  logic [ADDR_W-1:0] a4_i,
  input  logic [DATA_W-1:0] wd4_i,
  output logic [DATA_W-1:0] rd_o
);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic in_range;
  logic is_zero;

  assign in_range = ({1'b0, addr_i} < NUM_REGS_L);
  assign is_zero  = (ZERO_REG != 0) && (addr_i == ADDR_W'(RF_ZERO_ADDR));

  always_comb begin
    rd_o = '0;
    if (rst_i || is_zero || !in_range) begin
      rd_o = '0;
    end else if ((BYPASS != 0) && we4_i && (a4_i == addr_i)) begin
      rd_o = wd4_i;
    end else if ((BYPASS != 0) && we3_i && (a3_i == addr_i)) begin
      rd_o = wd3_i;
    end else begin
      rd_o = stored_i;
    end
  end
endmodule

// File: rtl/register_file_param.sv
// Parametrised 2-read / 2-write register file with asynchronous clear.
// Storage and write arbitration live here; read muxing is in rf_read_port.
module register_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  register_file_param_if.slave  bus
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // Port 4 is applied last so it wins a same-address conflict.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (!((ZERO_REG != 0) && (i == RF_ZERO_ADDR))) begin
        if (bus.WE3 && (bus.A3 == ADDR_W'(i))) regs_d[i] = bus.WD3;
        if (bus.WE4 && (bus.A4 == ADDR_W'(i))) regs_d[i] = bus.WD4;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Compare-based lookup: unimplemented addresses fall through to 0, never X.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.A1 == ADDR_W'(i)) stored1 = regs_q[i];
      if (bus.A2 == ADDR_W'(i)) stored2 = regs_q[i];
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .rst_i(RST), .addr_i(bus.A1), .stored_i(stored1),
    .we3_i(bus.WE3), .a3_i(bus.A3), .wd3_i(bus.WD3),
    .we4_i(bus.WE4), .a4_i(bus.A4), .wd4_i(bus.WD4),
    .rd_o(bus.RD1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd2 (
    .rst_i(RST), .addr_i(bus.A2), .stored_i(stored2),
    .we3_i(bus.WE3), .a3_i(bus.A3), .wd3_i(bus.WD3),
    .we4_i(bus.WE4), .a4_i(bus.A4), .wd4_i(bus.WD4),
    .rd_o(bus.RD2)
  );
endmodule
